// File: rtl/target_tracker.sv
// Blob-follow tracker: debounces vision hits into SEARCH/CONFIRM/TRACK/ARRIVED
// and reports the signed heading error of the most recent accepted hit.
module target_tracker #(
  parameter int IMG_WIDTH     = 640,
  parameter int CENTER_TOL    = 32,
  parameter int MIN_AREA      = 200,
  parameter int ARRIVE_AREA   = 20000,
  parameter int ACQ_FRAMES    = 3,
  parameter int LOST_FRAMES   = 5,
  parameter int ARRIVE_FRAMES = 4,
  parameter int TIMEOUT_CYC   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_valid,
  input  logic        blob_found,
  input  logic [9:0]  blob_x,
  input  logic [18:0] blob_area,
  output logic        target_acquired,
  output logic        target_arrived,
  output logic [10:0] heading_err,
  output logic [1:0]  trk_state
);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_TRACK   = 2'd2;
  localparam logic [1:0] S_ARRIVED = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [10:0] CENTER  = 11'(IMG_WIDTH / 2);
  localparam logic [10:0] X_LIMIT = 11'(IMG_WIDTH);
  localparam logic [10:0] TOL     = 11'(CENTER_TOL);
  localparam logic [18:0] A_MIN   = 19'(MIN_AREA);
  localparam logic [18:0] A_ARR   = 19'(ARRIVE_AREA);
  localparam logic [3:0]  N_ACQ   = 4'(ACQ_FRAMES);
  localparam logic [3:0]  N_LOST  = 4'(LOST_FRAMES);
  localparam logic [3:0]  N_ARR   = 4'(ARRIVE_FRAMES);
  localparam logic [TW-1:0] N_TMO = TW'(TIMEOUT_CYC);

  logic [1:0]    state_q, state_d;
  logic [3:0]    acq_q, acq_d;
  logic [3:0]    miss_q, miss_d;
  logic [3:0]    arr_q, arr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0]   head_q, head_d;
  logic          acq_o_q, acq_o_d;
  logic          arr_o_q, arr_o_d;

  logic [10:0] x_ext;
  logic [10:0] dx;
  logic [10:0] abs_dx;
  logic        in_range;
  logic        hit;
  logic        centred;
  logic        close_f;
  logic [3:0]  acq_inc;
  logic [3:0]  miss_inc;
  logic [3:0]  arr_inc;
  logic [TW-1:0] tmo_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Two's-complement offset from screen centre; magnitude fits in 10 bits
  assign x_ext    = {1'b0, blob_x};
  assign dx       = x_ext - CENTER;
  assign abs_dx   = dx[10] ? (~dx + 11'd1) : dx;
  assign in_range = x_ext < X_LIMIT;

  assign hit     = blob_found && (blob_area >= A_MIN) && in_range;
  assign centred = hit && (abs_dx <= TOL);
  assign close_f = hit && (blob_area >= A_ARR);

  assign acq_inc  = sat_inc(acq_q);
  assign miss_inc = sat_inc(miss_q);
  assign arr_inc  = sat_inc(arr_q);
  assign tmo_inc  = (tmo_q == N_TMO) ? tmo_q : tmo_q + TW'(1);

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    miss_d  = miss_q;
    arr_d   = arr_q;
    tmo_d   = tmo_q;
    head_d  = head_q;
    if (!enable) begin
      state_d = S_SEARCH;
      acq_d   = '0;
      miss_d  = '0;
      arr_d   = '0;
      tmo_d   = '0;
      head_d  = '0;
    end else if (frame_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_SEARCH: begin
          if (centred) begin
            state_d = S_CONFIRM;
            acq_d   = 4'd1;
          end
        end
        S_CONFIRM: begin
          if (centred) begin
            head_d = dx;
            if (acq_inc >= N_ACQ) begin
              state_d = S_TRACK;
              acq_d   = '0;
              miss_d  = '0;
              arr_d   = '0;
            end else begin
              acq_d = acq_inc;
            end
          end else begin
            state_d = S_SEARCH;
            acq_d   = '0;
            head_d  = '0;
          end
        end
        S_TRACK: begin
          if (hit) begin
            miss_d = '0;
            head_d = dx;
          end else begin
            miss_d = miss_inc;
          end
          if (close_f) begin
            arr_d = arr_inc;
            if (arr_inc >= N_ARR) begin
              state_d = S_ARRIVED;
            end
          end else begin
            arr_d = '0;
          end
          if (!hit && (miss_inc >= N_LOST)) begin
            state_d = S_SEARCH;
            acq_d   = '0;
            miss_d  = '0;
            arr_d   = '0;
            head_d  = '0;
          end
        end
        default: begin
        end
      endcase
    end else if ((state_q == S_CONFIRM) || (state_q == S_TRACK)) begin
      // Frame stream went quiet: drop the track once the budget runs out
      if (tmo_inc >= N_TMO) begin
        state_d = S_SEARCH;
        acq_d   = '0;
        miss_d  = '0;
        arr_d   = '0;
        tmo_d   = '0;
        head_d  = '0;
      end else begin
        tmo_d = tmo_inc;
      end
    end
  end

  assign acq_o_d = (state_d == S_TRACK) || (state_d == S_ARRIVED);
  assign arr_o_d = (state_d == S_ARRIVED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_SEARCH;
      acq_q   <= '0;
      miss_q  <= '0;
      arr_q   <= '0;
      tmo_q   <= '0;
      head_q  <= '0;
      acq_o_q <= 1'b0;
      arr_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
      miss_q  <= miss_d;
      arr_q   <= arr_d;
      tmo_q   <= tmo_d;
      head_q  <= head_d;
      acq_o_q <= acq_o_d;
      arr_o_q <= arr_o_d;
    end
  end

  assign target_acquired = acq_o_q;
  assign target_arrived  = arr_o_q;
  assign heading_err     = head_q;
  assign trk_state       = state_q;

endmodule

// File: tb/tb_target_tracker.sv
// Directed bench for target_tracker: expectations queued at drive time,
// popped and checked after the clock edge that applies them.
module tb_target_tracker;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        frame_valid;
  logic        blob_found;
  logic [9:0]  blob_x;
  logic [18:0] blob_area;
  logic        target_acquired;
  logic        target_arrived;
  logic [10:0] heading_err;
  logic [1:0]  trk_state;

  typedef struct packed {
    logic [1:0]  st;
    logic [10:0] hd;
    logic        hc;
  } exp_t;

  exp_t sb[$];
  int checks;
  int errors;

  target_tracker #(
    .TIMEOUT_CYC(100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .frame_valid     (frame_valid),
    .blob_found      (blob_found),
    .blob_x          (blob_x),
    .blob_area       (blob_area),
    .target_acquired (target_acquired),
    .target_arrived  (target_arrived),
    .heading_err     (heading_err),
    .trk_state       (trk_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input int st, input int head, input int hc);
    exp_t e;
    e.st = 2'(st);
    e.hd = 11'(head);
    e.hc = (hc != 0);
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty-queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "/state"}, 11'(trk_state), 11'(e.st));
      chk({tag, "/acq"}, 11'(target_acquired), 11'(e.st >= 2'd2));
      chk({tag, "/arr"}, 11'(target_arrived), 11'(e.st == 2'd3));
      if (e.hc) chk({tag, "/head"}, heading_err, e.hd);
    end
  endtask

  task automatic step(input string tag, input int fv, input int en,
                      input int found, input int x, input int area,
                      input int st, input int head, input int hc);
    @(negedge clk);
    frame_valid = (fv != 0);
    enable      = (en != 0);
    blob_found  = (found != 0);
    blob_x      = 10'(x);
    blob_area   = 19'(area);
    expect_push(st, head, hc);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    check_pop(tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    enable      = 1'b1;
    frame_valid = 1'b0;
    blob_found  = 1'b0;
    blob_x      = '0;
    blob_area   = '0;

    #12;
    expect_push(0, 0, 1);
    check_pop("reset");
    step("rst_held", 1, 1, 1, 320, 1000, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    step("off33", 1, 1, 1, 353, 1000, 0, 0, 1);
    step("area199", 1, 1, 1, 320, 199, 0, 0, 1);
    step("x700", 1, 1, 1, 700, 1000, 0, 0, 1);
    step("nofound", 1, 1, 0, 320, 1000, 0, 0, 1);
    step("nofv", 0, 1, 1, 320, 1000, 0, 0, 1);
    step("en_low", 1, 0, 1, 320, 1000, 0, 0, 1);
    step("edge288", 1, 1, 1, 288, 200, 1, 0, 0);
    step("edge352", 1, 1, 1, 352, 1000, 1, 32, 1);
    step("acq320", 1, 1, 1, 320, 1000, 2, 0, 1);
    step("dis1", 0, 0, 0, 0, 0, 0, 0, 1);

    step("acq_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("acq_f2", 1, 1, 1, 330, 1000, 1, 10, 1);
    step("acq_f3", 1, 1, 1, 330, 1000, 2, 10, 1);

    for (int i = 0; i < 4; i++) step("miss_a", 1, 1, 0, 330, 1000, 2, 10, 1);
    step("miss_hit", 1, 1, 1, 330, 1000, 2, 10, 1);
    for (int i = 0; i < 4; i++) step("miss_b", 1, 1, 0, 330, 1000, 2, 10, 1);
    step("lost", 1, 1, 0, 330, 1000, 0, 0, 1);

    step("acq2_f1", 1, 1, 1, 310, 1000, 1, 0, 0);
    step("acq2_f2", 1, 1, 1, 310, 1000, 1, -10, 1);
    step("acq2_f3", 1, 1, 1, 310, 1000, 2, -10, 1);
    for (int i = 0; i < 3; i++) step("close_a", 1, 1, 1, 310, 25000, 2, -10, 1);
    step("far", 1, 1, 1, 310, 1000, 2, -10, 1);
    for (int i = 0; i < 3; i++) step("close_b", 1, 1, 1, 310, 25000, 2, -10, 1);
    step("arrive", 1, 1, 1, 310, 25000, 3, -10, 1);
    step("arr_hold_f", 1, 1, 0, 320, 0, 3, -10, 1);
    for (int i = 0; i < 5; i++) step("arr_idle", 0, 1, 0, 0, 0, 3, -10, 1);
    step("dis2", 0, 0, 0, 0, 0, 0, 0, 1);

    step("cf_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("cf_f2", 1, 1, 1, 330, 1000, 1, 10, 1);
    step("cf_x400", 1, 1, 1, 400, 1000, 0, 0, 1);
    step("cf_g1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("fv_en0", 1, 0, 1, 330, 1000, 0, 0, 1);
    step("re_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("re_f2", 1, 1, 1, 330, 1000, 1, 10, 1);
    step("re_f3", 1, 1, 1, 330, 1000, 2, 10, 1);

    for (int i = 0; i < 98; i++) step("tmo_idle_a", 0, 1, 0, 0, 0, 2, 10, 1);
    step("tmo_fv99", 1, 1, 1, 330, 1000, 2, 10, 1);
    for (int i = 0; i < 99; i++) step("tmo_idle_b", 0, 1, 0, 0, 0, 2, 10, 1);
    step("tmo_trk", 0, 1, 0, 0, 0, 0, 0, 1);
    step("tmo_cf_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    for (int i = 0; i < 99; i++) step("tmo_idle_c", 0, 1, 0, 0, 0, 1, 0, 0);
    step("tmo_cf", 0, 1, 0, 0, 0, 0, 0, 1);

    step("r_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("r_f2", 1, 1, 1, 330, 1000, 1, 10, 1);
    step("r_f3", 1, 1, 1, 330, 1000, 2, 10, 1);
    for (int i = 0; i < 3; i++) step("r_close", 1, 1, 1, 330, 25000, 2, 10, 1);
    step("r_arrive", 1, 1, 1, 330, 25000, 3, 10, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_push(0, 0, 1);
    check_pop("async_rst");
    step("rst_hold", 1, 1, 1, 330, 25000, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("x700_trk", 1, 1, 1, 700, 1000, 0, 0, 1);
    step("post_f1", 1, 1, 1, 330, 1000, 1, 0, 0);
    step("post_f2", 1, 1, 1, 330, 1000, 1, 10, 1);
    step("post_f3", 1, 1, 1, 330, 1000, 2, 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/target_tracker.md
TARGET_TRACKER -- requirements
Module: target_tracker

Interface
REQ-001 Parameter IMG_WIDTH, default 640, horizontal image width in pixels; screen centre is IMG_WIDTH/2 = 320.
REQ-002 Parameter CENTER_TOL, default 32, maximum |blob_x - 320| for a frame to count as centred.
REQ-003 Parameter MIN_AREA, default 200, minimum blob_area for a frame to count as a hit.
REQ-004 Parameter ARRIVE_AREA, default 20000, blob_area at or above which a hit counts as close.
REQ-005 Parameter ACQ_FRAMES, default 3, range 2..15, consecutive centred hits needed to acquire.
REQ-006 Parameter LOST_FRAMES, default 5, range 1..15, consecutive misses needed to drop the track.
REQ-007 Parameter ARRIVE_FRAMES, default 4, range 1..15, consecutive close hits needed to declare arrival.
REQ-008 Parameter TIMEOUT_CYC, default 5_000_000, cycles without frame_valid before a track is dropped.
REQ-009 clk  input  1  system clock; all state changes on rising edge.
REQ-010 rst  input  1  asynchronous, active-high reset.
REQ-011 enable  input  1  high while navigate mode is active; low clears the tracker.
REQ-012 frame_valid  input  1  one-cycle pulse, once per frame, qualifying the blob_* inputs.
REQ-013 blob_found  input  1  vision stage found a candidate blob this frame.
REQ-014 blob_x  input  10  blob centroid column, unsigned, 0..IMG_WIDTH-1.
REQ-015 blob_area  input  19  blob pixel count, unsigned.
REQ-016 target_acquired  output  1  registered level; high in TRACK and ARRIVED.
REQ-017 target_arrived  output  1  registered level; high in ARRIVED only.
REQ-018 heading_err  output  11  signed, blob_x - 320 of the last accepted hit.
REQ-019 trk_state  output  2  current state: SEARCH=0, CONFIRM=1, TRACK=2, ARRIVED=3.

Function
REQ-020 A hit SHALL be blob_found && blob_area >= MIN_AREA; a miss is any frame that is not a hit; centred = hit && |blob_x - 320| <= CENTER_TOL; close = hit && blob_area >= ARRIVE_AREA.
REQ-021 Frame classification and state updates SHALL occur only on cycles with frame_valid=1 && enable=1; no other cycle changes state, except the enable and timeout rules.
REQ-022 SEARCH: a centred frame SHALL set acq_cnt=1 and go to CONFIRM; any other frame stays in SEARCH.
REQ-023 CONFIRM: a centred frame SHALL increment acq_cnt and go to TRACK when acq_cnt reaches ACQ_FRAMES; a non-centred frame SHALL clear acq_cnt and go to SEARCH.
REQ-024 TRACK: a hit SHALL clear miss_cnt; a miss SHALL increment miss_cnt and go to SEARCH (all counters cleared) when miss_cnt reaches LOST_FRAMES.
REQ-025 TRACK: a close frame SHALL increment arr_cnt and go to ARRIVED when arr_cnt reaches ARRIVE_FRAMES; a non-close frame SHALL clear arr_cnt. Centring is not required in TRACK.
REQ-026 ARRIVED SHALL be held, ignoring frames, until enable falls.
REQ-027 All counters SHALL saturate and never wrap.
REQ-028 Outputs SHALL be registered and change in the cycle after the qualifying frame_valid edge; acquire latency = ACQ_FRAMES frames.
REQ-029 heading_err SHALL load blob_x - 320, sign-extended to 11 bits, on every hit in CONFIRM or TRACK, hold otherwise, and read 0 in SEARCH.
REQ-030 In CONFIRM and TRACK, a cycle counter SHALL count cycles since the last frame_valid; on reaching TIMEOUT_CYC the block SHALL go to SEARCH with counters cleared. Every frame_valid clears the counter.
REQ-031 enable=0 SHALL, on the next clock edge, force SEARCH, clear all counters and heading_err, and drive target_acquired and target_arrived to 0, taking priority over frame_valid in the same cycle.
REQ-032 blob_x >= IMG_WIDTH SHALL be classified as a miss.

Reset
REQ-033 On rst: trk_state=SEARCH, all counters 0, target_acquired=0, target_arrived=0, heading_err=0, held for as long as rst is high.
REQ-034 Reset asserted mid-track SHALL abandon the track immediately; after release, acquisition requires ACQ_FRAMES fresh centred frames.

Verification
REQ-035 enable=1; 3 frames blob_x=330, area=1000 -> trk_state 0->1->1->2; target_acquired=1 one cycle after 3rd pulse; heading_err=10.
REQ-036 Acquire, then 4 misses, 1 hit, 4 misses -> remains TRACK; a 5th consecutive miss -> SEARCH, target_acquired=0.
REQ-037 In TRACK, areas 25000,25000,25000,1000,25000x4 -> ARRIVED only after the 4th consecutive close frame; target_arrived held until enable=0.
REQ-038 In CONFIRM (acq_cnt=2), blob_x=400 centred-fail -> SEARCH, heading_err=0; frame_valid and enable=0 in same cycle -> SEARCH, frame ignored.
REQ-039 In TRACK with TIMEOUT_CYC=100, no frame_valid for 100 cycles -> SEARCH; frame_valid at cycle 99 -> stays in TRACK.
REQ-040 rst pulsed asynchronously between clock edges while in ARRIVED -> all outputs 0 immediately; blob_x=700 frames never acquire.
